// File: rtl/minifunc_rr_arbiter.sv
// Purpose     : round-robin share of one 3-bit minimized-function unit between NREQ requesters.
// Latency     : accept in cycle T -> registered response (rsp_valid/rsp_data/rsp_id) in cycle T+1.
// Backpressure: rsp_ready=0 holds the response stable and blocks all grants (req_ready=0).
//
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   req_valid[NREQ]     per-requester request valid
//   req_data[3*NREQ]    operand A, requester i on bits [3i+2:3i]
//   req_ready[NREQ]     one-hot combinational accept
//   rsp_valid/rsp_data  registered result B[2:0] = {maj(A), ^A, ~A0}
//   rsp_id[IDW]         requester index the response belongs to
//   rsp_ready           consumer accepts the response
//   chk_err             (only with MINIFUNC_CHK_EN) sticky result-checker error
//
// Optional feature: define MINIFUNC_CHK_EN to add the chk_err output and its
// independent recomputation of every accepted result.

// The shared combinational function: B2 = majority, B1 = parity, B0 = ~A0.
module minifunc_unit (
    input  logic [2:0] a,
    output logic [2:0] b
);
    always_comb begin
        b    = 3'b000;
        b[2] = (a[2] & a[1]) | (a[2] & a[0]) | (a[1] & a[0]);
        b[1] = a[2] ^ a[1] ^ a[0];
        b[0] = ~a[0];
    end
endmodule

module minifunc_rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [3*NREQ-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic              rsp_valid,
    output logic [2:0]        rsp_data,
    output logic [IDW-1:0]    rsp_id,
    input  logic              rsp_ready
`ifdef MINIFUNC_CHK_EN
    ,
    output logic              chk_err
`endif
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [IDW-1:0]    ptr_q, ptr_d;
    logic [2:0]        rsp_data_q, rsp_data_d;
    logic [IDW-1:0]    rsp_id_q, rsp_id_d;

    logic              can_accept;
    logic              any_valid;
    logic              hi_found;
    logic [IDW-1:0]    hi_idx;
    logic [IDW-1:0]    lo_idx;
    logic [IDW-1:0]    gnt_idx;
    logic              grant;
    logic [2:0]        a_sel;
    logic [2:0]        f_out;

    assign can_accept = (state_q == IDLE) || rsp_ready;

    // Round-robin search as two priority passes: the lowest valid index at or
    // above ptr wins; if none exists the search wraps to the lowest valid
    // index overall. Iterating downward makes the last hit the lowest one.
    always_comb begin
        any_valid = 1'b0;
        hi_found  = 1'b0;
        hi_idx    = '0;
        lo_idx    = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                any_valid = 1'b1;
                lo_idx    = IDW'(i);
                if (i >= int'(ptr_q)) begin
                    hi_found = 1'b1;
                    hi_idx   = IDW'(i);
                end
            end
        end
        gnt_idx = hi_found ? hi_idx : lo_idx;
        grant   = can_accept && any_valid;
    end

    // One-hot accept. Held at 0 while reset is asserted so nothing downstream
    // sees a handshake that the register file is not going to take.
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = rst_n && grant && (gnt_idx == IDW'(i));
        end
    end

    // Operand mux for the granted requester; other requesters' data is ignored.
    always_comb begin
        a_sel = 3'b000;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_idx == IDW'(i)) begin
                a_sel = req_data[3*i +: 3];
            end
        end
    end

    minifunc_unit u_func (
        .a (a_sel),
        .b (f_out)
    );

    // Next-state / datapath. rsp_data and rsp_id only change on a grant, so
    // they keep their last values after the response drains.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        rsp_data_d = rsp_data_q;
        rsp_id_d   = rsp_id_q;
        case (state_q)
            IDLE: begin
                if (grant) begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (rsp_ready) begin
                    state_d = grant ? BUSY : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (grant) begin
            rsp_data_d = f_out;
            rsp_id_d   = gnt_idx;
            ptr_d      = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            rsp_data_q <= 3'b000;
            rsp_id_q   <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            rsp_data_q <= rsp_data_d;
            rsp_id_q   <= rsp_id_d;
        end
    end

    assign rsp_valid = (state_q == BUSY);
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;

`ifdef MINIFUNC_CHK_EN
    // Independent recomputation: majority and parity derived from a population
    // count rather than the gate-level expressions used in the unit.
    logic [1:0] ones_cnt;
    logic [2:0] chk_ref;
    logic       chk_err_q, chk_err_d;

    always_comb begin
        ones_cnt  = {1'b0, a_sel[0]} + {1'b0, a_sel[1]} + {1'b0, a_sel[2]};
        chk_ref   = {(ones_cnt >= 2'd2), ones_cnt[0], ~a_sel[0]};
        chk_err_d = chk_err_q;
        if (grant && (chk_ref != f_out)) begin
            chk_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_err_q <= 1'b0;
        end else begin
            chk_err_q <= chk_err_d;
        end
    end

    assign chk_err = chk_err_q;
`endif

endmodule

// File: tb/tb_minifunc_rr_arbiter.sv
// Bench for minifunc_rr_arbiter: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_minifunc_rr_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NREQ-1:0]   req_valid = '0;
    logic [3*NREQ-1:0] req_data = '0;
    logic [NREQ-1:0]   req_ready;
    logic              rsp_valid;
    logic [2:0]        rsp_data;
    logic [IDW-1:0]    rsp_id;
    logic              rsp_ready = 1'b0;
`ifdef MINIFUNC_CHK_EN
    logic              chk_err;
`endif

    int checks = 0;
    int errors = 0;

    // behavioural model state
    int          m_ptr = 0;
    logic        m_vld = 1'b0;
    logic [2:0]  m_dat = 3'b000;
    int          m_id  = 0;

    logic [2:0]  ftab [8];

    always #5 clk = ~clk;

    minifunc_rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .rsp_ready (rsp_ready)
`ifdef MINIFUNC_CHK_EN
        ,
        .chk_err   (chk_err)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Function from its arithmetic definition: count of ones decides majority and parity.
    function automatic logic [2:0] fref(input logic [2:0] a);
        int ones;
        ones = int'(a[0]) + int'(a[1]) + int'(a[2]);
        return {(ones >= 2), (ones % 2 == 1), (a % 2 == 0)};
    endfunction

    // First valid requester scanning ptr, ptr+1, ... modulo NREQ; -1 if none.
    function automatic int find_grant(input logic [NREQ-1:0] v, input int p);
        int idx;
        for (int k = 0; k < NREQ; k++) begin
            idx = (p + k) % NREQ;
            if (((v >> idx) & 1) != 0) return idx;
        end
        return -1;
    endfunction

    // Model update on the same edges as the design.
    always @(posedge clk or negedge rst_n) begin
        int g;
        if (!rst_n) begin
            m_ptr = 0;
            m_vld = 1'b0;
            m_dat = 3'b000;
            m_id  = 0;
        end else if (!m_vld || rsp_ready) begin
            g = find_grant(req_valid, m_ptr);
            if (g >= 0) begin
                m_dat = fref(3'(req_data >> (3 * g)));
                m_id  = g;
                m_vld = 1'b1;
                m_ptr = (g + 1) % NREQ;
            end else begin
                m_vld = 1'b0;
            end
        end
    end

    // Compare process: every falling edge, outputs against the model.
    always @(negedge clk) begin
        int g;
        logic [NREQ-1:0] exp_rr;
        exp_rr = '0;
        g = find_grant(req_valid, m_ptr);
        if (rst_n && (!m_vld || rsp_ready) && g >= 0) exp_rr = NREQ'(1 << g);
        chk("m_req_ready", 32'(req_ready), 32'(exp_rr));
        chk("m_rsp_valid", 32'(rsp_valid), 32'(m_vld));
        chk("m_rsp_data",  32'(rsp_data),  32'(m_dat));
        chk("m_rsp_id",    32'(rsp_id),    32'(m_id));
`ifdef MINIFUNC_CHK_EN
        chk("m_chk_err",   32'(chk_err),   32'd0);
`endif
    end

    initial begin
        logic [3:0] rr_seq [5];
        logic [2:0] d_seq  [4];
        ftab[0] = 3'b001; ftab[1] = 3'b010; ftab[2] = 3'b011; ftab[3] = 3'b100;
        ftab[4] = 3'b011; ftab[5] = 3'b100; ftab[6] = 3'b101; ftab[7] = 3'b110;
        rr_seq[0] = 4'b0001; rr_seq[1] = 4'b0010; rr_seq[2] = 4'b0100;
        rr_seq[3] = 4'b1000; rr_seq[4] = 4'b0001;
        d_seq[0] = 3'b001; d_seq[1] = 3'b110; d_seq[2] = 3'b011; d_seq[3] = 3'b100;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data",  32'(rsp_data),  32'd0);
        chk("rst_rsp_id",    32'(rsp_id),    32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        rst_n = 1'b1;

        // single request, A=011
        req_valid = 4'b0001; req_data = 12'b000_000_000_011; rsp_ready = 1'b1;
        @(negedge clk);
        chk("t1_req_ready", 32'(req_ready), 32'b0001);
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        chk("t1_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("t1_rsp_data",  32'(rsp_data),  32'b100);
        chk("t1_rsp_id",    32'(rsp_id),    32'd0);

        // all four valid from a fresh pointer
        @(posedge clk); #1;
        rst_n = 1'b0; #1; rst_n = 1'b1;
        req_valid = 4'b1111; req_data = 12'b101_010_111_000; rsp_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("t2_req_ready", 32'(req_ready), 32'(rr_seq[c]));
            if (c > 0) begin
                chk("t2_rsp_data", 32'(rsp_data), 32'(d_seq[c-1]));
                chk("t2_rsp_id",   32'(rsp_id),   32'(c - 1));
            end
            @(posedge clk); #1;
        end

        // backpressure: response from requester 0 (001) held 5 cycles
        req_valid = 4'b0110; rsp_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("t3_req_ready", 32'(req_ready), 32'd0);
            chk("t3_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("t3_rsp_data",  32'(rsp_data),  32'b001);
            chk("t3_rsp_id",    32'(rsp_id),    32'd0);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("t3_release_gnt", 32'(req_ready), 32'b0010);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t3_rsp_id1", 32'(rsp_id), 32'd1);
        chk("t3_rsp_d1",  32'(rsp_data), 32'b110);

        // requester 3 then wrap to requester 0
        @(posedge clk); #1;
        req_valid = 4'b1000;
        @(negedge clk);
        chk("t4_gnt3", 32'(req_ready), 32'b1000);
        @(posedge clk); #1;
        req_valid = 4'b0001;
        @(negedge clk);
        chk("t4_gnt0", 32'(req_ready), 32'b0001);
        chk("t4_id3",  32'(rsp_id), 32'd3);
        @(posedge clk); #1;
        req_valid = '0; rsp_ready = 1'b0;
        @(negedge clk);
        chk("t4_id0",  32'(rsp_id), 32'd0);
        chk("t4_d0",   32'(rsp_data), 32'b001);

        // asynchronous reset while a response is pending
        @(posedge clk); #1;
        chk("t5_pending", 32'(rsp_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t5_async_vld", 32'(rsp_valid), 32'd0);
        chk("t5_async_id",  32'(rsp_id),    32'd0);
        #1;
        rst_n = 1'b1; req_valid = 4'b1010; rsp_ready = 1'b1;
        #1;
        chk("t5_first_gnt", 32'(req_ready), 32'b0010);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t5_rsp_id", 32'(rsp_id), 32'd1);

        // sweep all operands through requester 2
        @(posedge clk); #1;
        req_valid = 4'b0100;
        for (int a = 0; a < 8; a++) begin
            req_data = '0;
            req_data[8:6] = 3'(a);
            @(negedge clk);
            chk("t6_gnt2", 32'(req_ready), 32'b0100);
            @(posedge clk); #1;
            @(negedge clk);
            chk("t6_rsp_data", 32'(rsp_data), 32'(ftab[a]));
            chk("t6_rsp_id",   32'(rsp_id),   32'd2);
`ifdef MINIFUNC_CHK_EN
            chk("t6_chk_err",  32'(chk_err),  32'd0);
`endif
            @(posedge clk); #1;
        end

        // randomized traffic; the compare process does the checking
        for (int n = 0; n < 3000; n++) begin
            case ($urandom_range(0, 3))
                0:       req_valid = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
                1:       req_valid = 4'(1 << $urandom_range(0, 3));
                default: req_valid = 4'($urandom_range(0, 15));
            endcase
            req_data  = 12'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 199) == 0) begin
                rst_n = 1'b0; #1; rst_n = 1'b1;
            end
            @(posedge clk); #1;
        end

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
